// File: rtl/xgmii_rx_link_monitor.sv
`timescale 1ns/1ps
// xgmii_rx_link_monitor
//   Per-port receive link monitor on the 64-bit XGMII RX path.
//   Qualifies PHY block lock / high BER into a debounced link_up, decodes
//   local/remote fault ordered sets, counts frame starts and error words,
//   and drives link/activity LED indications.
// Ports
//   clk, rst_n            : RX clock, async active-low reset
//   xgmii_rxd, xgmii_rxc  : 64-bit RX data / 8-bit per-lane control flags
//   rx_block_lock, rx_hi_ber : PHY status, asynchronous to clk
//   clear_counts          : sync pulse zeroing frame_count and err_count
//   link_up, local_fault, remote_fault : link and fault status
//   frame_count, err_count: saturating counters
//   led_link, led_act     : LED drives
module xgmii_rx_link_monitor #(
  parameter int LOCK_DEBOUNCE     = 1024,
  parameter int FAULT_OS_COUNT    = 4,
  parameter int FAULT_CLEAR_WORDS = 64,
  parameter int BLINK_CYCLES      = 7812500,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          xgmii_rxd,
  input  logic [7:0]           xgmii_rxc,
  input  logic                 rx_block_lock,
  input  logic                 rx_hi_ber,
  input  logic                 clear_counts,
  output logic                 link_up,
  output logic                 local_fault,
  output logic                 remote_fault,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 led_link,
  output logic                 led_act
);

  localparam int DBC_W  = (LOCK_DEBOUNCE > 1) ? $clog2(LOCK_DEBOUNCE) : 1;
  localparam int FCNT_W = $clog2(FAULT_OS_COUNT + 1);
  localparam int CLR_W  = (FAULT_CLEAR_WORDS > 1) ? $clog2(FAULT_CLEAR_WORDS) : 1;
  localparam int BCNT_W = $clog2(BLINK_CYCLES + 1);

  localparam logic [DBC_W-1:0]  DBC_LAST = DBC_W'(LOCK_DEBOUNCE - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FAULT_OS_COUNT);
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(FAULT_CLEAR_WORDS - 1);

  typedef enum logic [1:0] {ST_DOWN, ST_WAIT, ST_UP} state_t;
  typedef enum logic [1:0] {FT_NONE, FT_LOCAL, FT_REMOTE} ftype_t;

  logic lock_meta_q, lock_s_q, ber_meta_q, ber_s_q;
  logic good;

  state_t           state_q, state_d;
  logic [DBC_W-1:0] dbc_q, dbc_d;
  logic             link_up_q, link_up_d;

  ftype_t            ftype_q, ftype_d, word_ft;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              local_fault_q, local_fault_d;
  logic              remote_fault_q, remote_fault_d;

  logic                 has_start, has_err;
  logic [CNT_WIDTH-1:0] frame_q, frame_d, err_q, err_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;

  // A column is a fault ordered set: 0x9C control in the first lane, data
  // 0x00,0x00 in the middle lanes, and 0x01/0x02 selecting local/remote.
  function automatic ftype_t col_fault(input logic [31:0] d, input logic [3:0] c);
    col_fault = FT_NONE;
    if (c == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
      if (d[31:24] == 8'h01)      col_fault = FT_LOCAL;
      else if (d[31:24] == 8'h02) col_fault = FT_REMOTE;
    end
  endfunction

  assign good = lock_s_q & ~ber_s_q;

  // Link qualification FSM: lock must be continuously good for the whole
  // debounce window; any loss drops the link on the next cycle.
  always_comb begin
    state_d = state_q;
    dbc_d   = dbc_q;
    case (state_q)
      ST_DOWN: begin
        if (good) begin
          state_d = ST_WAIT;
          dbc_d   = '0;
        end
      end
      ST_WAIT: begin
        if (!good)                state_d = ST_DOWN;
        else if (dbc_q == DBC_LAST) state_d = ST_UP;
        else                      dbc_d = dbc_q + DBC_W'(1);
      end
      ST_UP: begin
        if (!good) state_d = ST_DOWN;
      end
      default: state_d = ST_DOWN;
    endcase
    link_up_d = (state_q == ST_UP) && good;
  end

  // Fault decode: lanes 0-3 column has priority over lanes 4-7. A run of
  // fault-free words long enough clears the fault state entirely.
  always_comb begin
    ftype_d        = ftype_q;
    fcnt_d         = fcnt_q;
    clr_cnt_d      = clr_cnt_q;
    local_fault_d  = local_fault_q;
    remote_fault_d = remote_fault_q;
    word_ft        = col_fault(xgmii_rxd[31:0], xgmii_rxc[3:0]);
    if (word_ft == FT_NONE) word_ft = col_fault(xgmii_rxd[63:32], xgmii_rxc[7:4]);

    if (word_ft != FT_NONE) begin
      clr_cnt_d = '0;
      if (word_ft == ftype_q) begin
        if (fcnt_q != FCNT_MAX) fcnt_d = fcnt_q + FCNT_W'(1);
      end else begin
        ftype_d = word_ft;
        fcnt_d  = FCNT_W'(1);
      end
      if (fcnt_d == FCNT_MAX) begin
        local_fault_d  = (word_ft == FT_LOCAL);
        remote_fault_d = (word_ft == FT_REMOTE);
      end
    end else if (clr_cnt_q == CLR_LAST) begin
      clr_cnt_d      = '0;
      fcnt_d         = '0;
      local_fault_d  = 1'b0;
      remote_fault_d = 1'b0;
    end else begin
      clr_cnt_d = clr_cnt_q + CLR_W'(1);
    end
  end

  // Frame/error counting and activity stretch; counting is gated by the
  // registered link state, and clear_counts beats a same-cycle increment.
  always_comb begin
    has_start = (xgmii_rxc[0] && xgmii_rxd[7:0] == 8'hFB) ||
                (xgmii_rxc[4] && xgmii_rxd[39:32] == 8'hFB);
    has_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (xgmii_rxc[i] && xgmii_rxd[8*i +: 8] == 8'hFE) has_err = 1'b1;
    end

    frame_d = frame_q;
    err_d   = err_q;
    if (clear_counts) begin
      frame_d = '0;
      err_d   = '0;
    end else if (link_up_q) begin
      if (has_start && frame_q != '1) frame_d = frame_q + CNT_WIDTH'(1);
      if (has_err && err_q != '1)     err_d   = err_q + CNT_WIDTH'(1);
    end

    bcnt_d = bcnt_q;
    if (link_up_q && has_start) bcnt_d = BCNT_W'(BLINK_CYCLES);
    else if (bcnt_q != '0)      bcnt_d = bcnt_q - BCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q    <= 1'b0;
      lock_s_q       <= 1'b0;
      ber_meta_q     <= 1'b0;
      ber_s_q        <= 1'b0;
      state_q        <= ST_DOWN;
      dbc_q          <= '0;
      link_up_q      <= 1'b0;
      ftype_q        <= FT_NONE;
      fcnt_q         <= '0;
      clr_cnt_q      <= '0;
      local_fault_q  <= 1'b0;
      remote_fault_q <= 1'b0;
      frame_q        <= '0;
      err_q          <= '0;
      bcnt_q         <= '0;
    end else begin
      lock_meta_q    <= rx_block_lock;
      lock_s_q       <= lock_meta_q;
      ber_meta_q     <= rx_hi_ber;
      ber_s_q        <= ber_meta_q;
      state_q        <= state_d;
      dbc_q          <= dbc_d;
      link_up_q      <= link_up_d;
      ftype_q        <= ftype_d;
      fcnt_q         <= fcnt_d;
      clr_cnt_q      <= clr_cnt_d;
      local_fault_q  <= local_fault_d;
      remote_fault_q <= remote_fault_d;
      frame_q        <= frame_d;
      err_q          <= err_d;
      bcnt_q         <= bcnt_d;
    end
  end

  assign link_up      = link_up_q;
  assign local_fault  = local_fault_q;
  assign remote_fault = remote_fault_q;
  assign frame_count  = frame_q;
  assign err_count    = err_q;
  assign led_link     = link_up_q & ~local_fault_q & ~remote_fault_q;
  assign led_act      = (bcnt_q != '0);

endmodule
